// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - instruction fetch and program counter stage
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  input  logic        use_alternative_PC,
  input  logic [1:0]  choose_alternative_PC,
  input  logic        alu_zero,
  input  logic [31:0] jr_target,
  input  logic        stall,
  output logic [31:0] instr_count,
  output logic        align_fault
);

  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JUMP   = 2'd2;
  localparam logic [1:0] SEL_JR     = 2'd3;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC
  } state_t;

  state_t      state;
  logic [31:0] pc4;
  logic [31:0] jump_tgt;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic        br_taken;
  logic [31:0] next_pc;
  logic        jr_fault;

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign imem_addr = pc;
  assign pc_plus8  = pc + 32'd8;

  // Request and valid are gated by reset so both drop the instant reset rises.
  assign imem_req    = !reset && (state != S_EXEC);
  assign instr_valid = !reset && (state == S_EXEC);

  // Next-PC selection; JAL always jumps, otherwise the decoder's select decides.
  always_comb begin
    pc4      = pc + 32'd4;
    jump_tgt = {pc4[31:28], instr[25:0], 2'b00};
    br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
    br_tgt   = pc4 + br_off;
    br_taken = ((opcode == OP_BEQ) && alu_zero) || ((opcode == OP_BNE) && !alu_zero);
    next_pc  = pc4;
    jr_fault = 1'b0;
    if (opcode == OP_JAL) begin
      next_pc = jump_tgt;
    end else if (use_alternative_PC) begin
      case (choose_alternative_PC)
        SEL_BRANCH: next_pc = br_taken ? br_tgt : pc4;
        SEL_JUMP:   next_pc = jump_tgt;
        SEL_JR: begin
          next_pc  = {jr_target[31:2], 2'b00};
          jr_fault = |jr_target[1:0];
        end
        default:    next_pc = pc4;
      endcase
    end
  end

  // Fetch/execute sequencer; PC, counter and fault flag only move on an EXEC exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_count <= 32'h0;
      align_fault <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            instr <= imem_rdata;
            state <= S_EXEC;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ready) begin
            instr <= imem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            pc          <= next_pc;
            instr_count <= instr_count + 32'd1;
            if (jr_fault) begin
              align_fault <= 1'b1;
            end
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        use_alternative_PC;
  logic [1:0]  choose_alternative_PC;
  logic        alu_zero;
  logic [31:0] jr_target;
  logic        stall;
  logic [31:0] instr_count;
  logic        align_fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_fault;

  localparam logic [31:0] NOP = 32'h0000_0020;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .opcode(opcode),
    .funct(funct),
    .instr_valid(instr_valid),
    .pc(pc),
    .pc_plus8(pc_plus8),
    .use_alternative_PC(use_alternative_PC),
    .choose_alternative_PC(choose_alternative_PC),
    .alu_zero(alu_zero),
    .jr_target(jr_target),
    .stall(stall),
    .instr_count(instr_count),
    .align_fault(align_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference next PC from the instruction-set rules.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic ua, input logic [1:0] sel,
                                           input logic z, input logic [31:0] jt);
    logic [31:0]        p4;
    logic [31:0]        jtarget;
    int unsigned        opc;
    logic signed [15:0] imm;
    int                 off;
    p4      = p + 32'd4;
    opc     = w >> 26;
    jtarget = (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    imm     = w[15:0];
    off     = imm;
    if (opc == 3) return jtarget;
    if (!ua) return p4;
    if (sel == 2'd1) begin
      if ((opc == 4 && z) || (opc == 5 && !z)) return p4 + 32'(off * 4);
      return p4;
    end
    if (sel == 2'd2) return jtarget;
    if (sel == 2'd3) return jt & ~32'h3;
    return p4;
  endfunction

  function automatic logic ref_fault(input logic [31:0] w, input logic ua,
                                     input logic [1:0] sel, input logic [31:0] jt);
    return ((w >> 26) != 3) && ua && (sel == 2'd3) && ((jt % 4) != 0);
  endfunction

  // One full instruction: fetch with dly wait cycles, st stall cycles, then exit EXEC.
  task automatic do_instr(input logic [31:0] w, input int dly, input logic ua,
                          input logic [1:0] sel, input logic z, input logic [31:0] jt,
                          input int st);
    int          nvalid;
    logic [31:0] exp_pc;
    #1;
    chk("fetch_req", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_valid", instr_valid, 1'b0);
    for (int i = 0; i <= dly; i++) begin
      if (i > 0) begin
        step();
        chk("wait_req", imem_req, 1'b1);
        chk("wait_addr", imem_addr, m_pc);
        chk("wait_valid", instr_valid, 1'b0);
      end
      imem_ready = (i == dly);
      imem_rdata = (i == dly) ? w : $urandom();
    end
    step();
    imem_ready = 1'b0;
    nvalid = 0;
    chk("exec_valid", instr_valid, 1'b1);
    chk("exec_req", imem_req, 1'b0);
    chk("exec_instr", instr, w);
    chk("exec_opcode", opcode, w >> 26);
    chk("exec_funct", funct, w & 32'h3F);
    chk("exec_pc", pc, m_pc);
    chk("exec_pc_plus8", pc_plus8, m_pc + 32'd8);
    if (instr_valid === 1'b1) nvalid++;
    for (int s = 0; s < st; s++) begin
      stall                 = 1'b1;
      use_alternative_PC    = 1'($urandom());
      choose_alternative_PC = 2'($urandom());
      alu_zero              = 1'($urandom());
      jr_target             = $urandom();
      imem_ready            = 1'($urandom());
      imem_rdata            = $urandom();
      step();
      chk("stall_pc", pc, m_pc);
      chk("stall_instr", instr, w);
      chk("stall_count", instr_count, m_cnt);
      if (instr_valid === 1'b1) nvalid++;
    end
    stall                 = 1'b0;
    use_alternative_PC    = ua;
    choose_alternative_PC = sel;
    alu_zero              = z;
    jr_target             = jt;
    imem_ready            = 1'b0;
    exp_pc  = ref_next(m_pc, w, ua, sel, z, jt);
    m_fault = m_fault | ref_fault(w, ua, sel, jt);
    m_pc    = exp_pc;
    m_cnt   = m_cnt + 32'd1;
    step();
    use_alternative_PC    = 1'($urandom());
    choose_alternative_PC = 2'($urandom());
    alu_zero              = 1'($urandom());
    jr_target             = $urandom();
    chk("next_pc", pc, m_pc);
    chk("instr_count", instr_count, m_cnt);
    chk("align_fault", align_fault, m_fault);
    chk("back_to_fetch", imem_req, 1'b1);
    chk("valid_cycles", nvalid, st + 1);
  endtask

  task automatic jr_to(input logic [31:0] t);
    do_instr(NOP, 0, 1'b1, 2'd3, 1'b0, t, 0);
  endtask

  initial begin
    logic [31:0] r;
    logic [5:0]  opc;
    reset = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    use_alternative_PC = 1'b0;
    choose_alternative_PC = 2'd0;
    alu_zero = 1'b0;
    jr_target = 32'h0;
    stall = 1'b0;
    m_pc = 32'h0;
    m_cnt = 32'h0;
    m_fault = 1'b0;
    step();
    step();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_count", instr_count, 32'h0);
    chk("rst_fault", align_fault, 1'b0);
    reset = 1'b0;

    do_instr(NOP, 0, 1'b0, 2'd0, 1'b0, 32'h0, 0);
    do_instr(NOP, 0, 1'b0, 2'd0, 1'b0, 32'h0, 0);
    do_instr(NOP, 0, 1'b0, 2'd0, 1'b0, 32'h0, 0);
    chk("three_nops_count", instr_count, 32'd3);
    chk("three_nops_pc", pc, 32'hC);
    do_instr(NOP, 2, 1'b0, 2'd0, 1'b0, 32'h0, 0);

    do_instr(32'h1085_0003, 0, 1'b1, 2'd1, 1'b1, 32'h0, 0);
    chk("beq_taken", pc, 32'h20);
    jr_to(32'h10);
    do_instr(32'h1085_0003, 1, 1'b1, 2'd1, 1'b0, 32'h0, 0);
    chk("beq_not_taken", pc, 32'h14);
    jr_to(32'h10);
    do_instr(32'h1085_FFFF, 0, 1'b1, 2'd1, 1'b1, 32'h0, 0);
    chk("beq_back", pc, 32'h10);
    do_instr(32'h1485_0003, 0, 1'b1, 2'd1, 1'b0, 32'h0, 0);
    chk("bne_taken", pc, 32'h20);

    jr_to(32'h0040_0000);
    do_instr(32'h0800_0040, 0, 1'b1, 2'd2, 1'b0, 32'h0, 0);
    chk("j_target", pc, 32'h100);
    jr_to(32'h0040_0000);
    do_instr(32'h0C00_0040, 0, 1'b0, 2'd0, 1'b0, 32'h0, 0);
    chk("jal_target", pc, 32'h100);
    chk("fault_clear", align_fault, 1'b0);

    jr_to(32'h0000_0203);
    chk("jr_misaligned_pc", pc, 32'h200);
    chk("jr_fault_set", align_fault, 1'b1);
    do_instr(NOP, 1, 1'b0, 2'd0, 1'b0, 32'h0, 0);
    chk("fault_sticky", align_fault, 1'b1);
    jr_to(32'h0000_0300);
    chk("jr_aligned_pc", pc, 32'h300);
    chk("fault_unchanged", align_fault, 1'b1);

    do_instr(NOP, 0, 1'b0, 2'd0, 1'b0, 32'h0, 3);

    jr_to(32'hFFFF_FFFC);
    do_instr(NOP, 0, 1'b0, 2'd0, 1'b0, 32'h0, 0);
    chk("pc_wrap", pc, 32'h0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom();
      case ($urandom_range(0, 5))
        0: opc = 6'd0;
        1: opc = 6'd2;
        2: opc = 6'd3;
        3: opc = 6'd4;
        4: opc = 6'd5;
        default: opc = 6'h23;
      endcase
      do_instr({opc, r[25:0]}, $urandom_range(0, 3), 1'($urandom()), 2'($urandom()),
               1'($urandom()), $urandom(), $urandom_range(0, 2));
    end

    #1;
    imem_ready = 1'b0;
    step();
    chk("pre_rst_wait_req", imem_req, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_count", instr_count, 32'h0);
    chk("mid_rst_fault", align_fault, 1'b0);
    chk("mid_rst_valid", instr_valid, 1'b0);
    imem_ready = 1'b1;
    imem_rdata = $urandom();
    step();
    imem_ready = 1'b0;
    reset = 1'b0;
    m_pc = 32'h0;
    m_cnt = 32'h0;
    m_fault = 1'b0;
    do_instr(NOP, 0, 1'b0, 2'd0, 1'b0, 32'h0, 0);
    chk("post_rst_count", instr_count, 32'd1);
    chk("post_rst_pc", pc, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch and program-counter stage directly upstream of the instruction decoder / control FSM.
- Holds the PC and fetches each instruction from instruction memory over a req/ready handshake.
- Presents the latched instruction, with opcode and funct split out, to the decoder.
- Computes the next PC from the decoder's use_alternative_PC / choose_alternative_PC, the ALU zero flag and the JR register value; counts retired instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; equals pc.
imem_ready  input  1  memory has valid imem_rdata this cycle.
imem_rdata  input  32  instruction word from memory.
instr  output  32  latched instruction.
opcode  output  6  instr[31:26], to decoder.
funct  output  6  instr[5:0], to decoder.
instr_valid  output  1  high during EXEC; decoder outputs are meaningful.
pc  output  32  address of the current instruction.
pc_plus8  output  32  pc+8, JAL link value.
use_alternative_PC  input  1  from decoder.
choose_alternative_PC  input  2  from decoder: 1 = branch, 2 = J/JAL, 3 = JR.
alu_zero  input  1  ALU result is zero (rs == rt for branches).
jr_target  input  32  r[rs] value for JR.
stall  input  1  holds the stage in EXEC.
instr_count  output  32  retired-instruction counter.
align_fault  output  1  sticky; set when a JR target is misaligned.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- Reset values:
  - pc = RESET_PC; state = FETCH; instr = 0; instr_count = 0; align_fault = 0.
  - imem_req = 0 and instr_valid = 0 while reset is high.
- Reset mid-operation: takes effect immediately in any state. An outstanding request is abandoned; an imem_ready arriving later is ignored unless the stage is in FETCH or WAIT.
- States: FETCH, WAIT, EXEC.
  - FETCH: imem_req = 1, imem_addr = pc. If imem_ready, latch imem_rdata into instr and go to EXEC; otherwise go to WAIT.
  - WAIT: imem_req = 1 and imem_addr stays stable. On imem_ready, latch instr and go to EXEC.
  - EXEC: instr_valid = 1, imem_req = 0.
    - If stall: stay in EXEC; pc, instr and counter are held.
    - Else: pc <= next_pc, instr_count <= instr_count + 1 (wraps at 2^32), go to FETCH.
- Latency:
  - Zero-wait memory: 2 cycles per instruction (FETCH, EXEC).
  - Each extra memory wait cycle adds one cycle in WAIT.
- next_pc, combinational from the current pc and instr (pc4 = pc + 4):
  - opcode == 6'b000011 (JAL): {pc4[31:28], instr[25:0], 2'b00}, regardless of use_alternative_PC.
  - use_alternative_PC = 0: pc4.
  - sel 1, branch:
    - Taken when (opcode == 6'b000100 and alu_zero) or (opcode == 6'b000101 and !alu_zero).
    - Target = pc4 + (sign_extend(instr[15:0]) << 2), 32-bit wrap-around add.
    - Not taken gives pc4.
  - sel 2, J: {pc4[31:28], instr[25:0], 2'b00}.
  - sel 3, JR: {jr_target[31:2], 2'b00}. If jr_target[1:0] != 0, set align_fault (sticky until reset). Execution continues at the aligned address.
  - sel 0 with use_alternative_PC = 1: pc4.
- Sampling: next_pc inputs are sampled only in the EXEC cycle that leaves EXEC; their values in other cycles are ignored.
- PC wrap: pc 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no flag.
- Derived outputs: opcode and funct are direct slices of instr. pc_plus8 = pc + 8, combinational.

Test Plan:
- Reset then zero-wait memory, NOP words (0x0000_0020) -> imem_addr sequence 0x0, 0x4, 0x8 with one FETCH and one EXEC cycle each; instr_count = 3 after three EXEC exits.
- imem_ready delayed 2 cycles -> FETCH, WAIT, WAIT, EXEC; imem_addr constant throughout; instr_valid high for exactly 1 cycle.
- BEQ branch at pc 0x10:
  - instr 0x1085_0003, sel 1, alu_zero = 1 -> next pc 0x20; alu_zero = 0 -> 0x14.
  - imm 0xFFFF, taken -> 0x10.
  - Same instr word with BNE opcode (0x1485_0003) and alu_zero = 0 -> 0x20.
- Jumps from pc 0x0040_0000:
  - J 0x0800_0040, sel 2 -> 0x0000_0100.
  - JAL 0x0C00_0040 with use_alternative_PC = 0 -> 0x0000_0100; pc_plus8 = 0x0040_0008 during EXEC.
- JR, sel 3:
  - jr_target 0x0000_0203 -> pc 0x0000_0200, align_fault = 1, still set after subsequent instructions.
  - jr_target 0x0000_0300 -> 0x300, fault unchanged.
- stall held 3 cycles in EXEC -> pc, instr and instr_count constant, instr_valid high 4 cycles. Reset asserted during WAIT -> pc = RESET_PC, instr_count = 0, imem_req low immediately, FETCH on release.
